mem_wait_responder: RTL and testbench
=====================================

# mem_wait_responder

Parametrised responder for the minrv32 native memory interface (`mem_valid`/`mem_ready`/`mem_addr`/`mem_wdata`/`mem_wstrb`/`mem_rdata`), used in simulation and formal benches in place of an ideal memory. It holds a word-addressed RAM, inserts a configurable number of wait states plus bench-injected stalls, and applies byte-strobed writes. It also monitors the core's side of the handshake and raises sticky protocol-error flags. A backdoor load port preloads program images. Fetch and write counters support coverage goals.

## Interface
- `DEPTH_LOG2`, 8: RAM holds 2^DEPTH_LOG2 32-bit words.
- `WAIT_CYCLES`, 2: minimum wait states between acceptance and `mem_ready`, range 0..255.

- `clk`  in  1  sole clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `mem_valid`  in  1  request from core.
- `mem_instr`  in  1  request is an instruction fetch.
- `mem_addr`  in  32  byte address.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte write strobes; 0 means read.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  32  read data; valid only while `mem_ready`=1, otherwise 0.
- `stall_in`  in  1  extra wait-state injection from bench/solver.
- `load_en`  in  1  backdoor write enable.
- `load_addr`  in  DEPTH_LOG2  backdoor word index.
- `load_data`  in  32  backdoor word.
- `protocol_err`  out  3  sticky flags: [0] valid dropped, [1] request changed, [2] misaligned.
- `fetch_count`  out  32  completed instruction fetches.
- `write_count`  out  32  completed writes (`mem_wstrb`≠0).

## Operation
- FSM with states IDLE, WAIT and RESP; the reset state is IDLE.
- IDLE: when `mem_valid`=1, capture `mem_addr`, `mem_wdata`, `mem_wstrb` and `mem_instr`, and load the counter with `WAIT_CYCLES`.
  - Go to WAIT if `WAIT_CYCLES`>0 or `stall_in`=1.
  - Otherwise go to RESP.
- WAIT:
  - If `stall_in`=1: hold; the counter is unchanged.
  - Else if counter>1: decrement.
  - Else: go to RESP.
- RESP:
  - `mem_ready`=1 for exactly this cycle.
  - `mem_rdata` = RAM word at the captured index, pre-write value, for reads and writes alike.
  - At the closing edge, bytes with strobe set are written and the FSM goes to IDLE.
  - A request present in the cycle after RESP is treated as new.
- Word index = `mem_addr[DEPTH_LOG2+1:2]`. Upper bits are ignored, so addresses alias modulo the RAM size.
- Misaligned address (`mem_addr[1:0]`≠0) sets flag [2]. The access still uses the truncated index.
- Protocol monitor, active in WAIT and RESP:
  - `mem_valid`=0 sets [0]; the transaction still completes.
  - `mem_addr`, `mem_wdata` or `mem_wstrb` differing from the captured value sets [1].
  - Flags are sticky until reset.
- Counters increment at the RESP edge. `fetch_count` increments if the captured instr bit is set. `write_count` increments if the captured strobe≠0. Both wrap 2^32−1→0.
- Backdoor load writes the full word at the clock edge in any state.
- Same word written by a RESP write and `load_en` in the same cycle: the bus write wins for strobed bytes; the other bytes take `load_data`.
- RAM is not reset; its contents survive `resetn`.

## Timing
- Request accepted in IDLE at cycle T. `mem_ready` is high in cycle T+1+`WAIT_CYCLES`+(number of `stall_in`-high cycles in the WAIT/accept window). With `WAIT_CYCLES`=0 and no stall, `mem_ready` is high at T+1.
- Back-to-back requests: minimum issue interval is `WAIT_CYCLES`+2 cycles.
- Reset values, forced immediately and asynchronously: `mem_ready`=0, `mem_rdata`=0, `protocol_err`=0, `fetch_count`=0, `write_count`=0, FSM in IDLE.
- Reset during WAIT or RESP abandons the transaction: no write, no counter update.
- Backdoor-loaded data is visible to a RESP beginning on the following cycle.

## Test plan
- Read latency, `WAIT_CYCLES`=2: preload word 5 = 0x00A00093; read addr 0x14 with instr=1, accepted at T → `mem_ready` only at T+3, `mem_rdata`=0x00A00093, `fetch_count`=1.
- Byte-strobe write: word 3 = 0x11223344; write 0xAABBCCDD with strobe 0b0101 to 0x0C → that RESP returns 0x11223344; a later read returns 0x11BB33DD; `write_count`=1.
- Stall injection: `stall_in` high for 4 cycles during WAIT, `WAIT_CYCLES`=2, accepted at T → `mem_ready` at T+7, exactly one cycle wide.
- Protocol errors:
  - Drop `mem_valid` mid-WAIT → `protocol_err`=3'b001, ready still issued.
  - Change `mem_addr` in WAIT → bit [1] set.
  - Address 0x102 → bit [2] set.
  - All flags clear only on `resetn`=0.
- Aliasing, `DEPTH_LOG2`=8: write 0xDEADBEEF to 0x400, then read 0x000 → 0xDEADBEEF.
- Reset mid-write: assert `resetn`=0 during WAIT of a write to word 7 → word 7 unchanged, counters 0, `mem_ready`=0 immediately.

Source files
------------

// File: rtl/mem_wait_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_responder
// Brief    : Wait-state memory responder with protocol monitor and backdoor load
// Revision : 1.0 - initial release
// ============================================================================
module mem_wait_responder #(
   parameter int DEPTH_LOG2  = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  mem_valid,
   input  logic                  mem_instr,
   input  logic [31:0]           mem_addr,
   input  logic [31:0]           mem_wdata,
   input  logic [3:0]            mem_wstrb,
   output logic                  mem_ready,
   output logic [31:0]           mem_rdata,
   input  logic                  stall_in,
   input  logic                  load_en,
   input  logic [DEPTH_LOG2-1:0] load_addr,
   input  logic [31:0]           load_data,
   output logic [2:0]            protocol_err,
   output logic [31:0]           fetch_count,
   output logic [31:0]           write_count
);

   localparam int         c_depth     = 1 << DEPTH_LOG2;
   localparam logic [7:0] c_wait_init = 8'(WAIT_CYCLES);
   localparam logic       c_has_wait  = (WAIT_CYCLES > 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                r_state;
   logic [31:0]           r_addr;
   logic [31:0]           r_wdata;
   logic [3:0]            r_wstrb;
   logic                  r_instr;
   logic [7:0]            r_cnt;
   logic                  r_ready;
   logic [2:0]            r_err;
   logic [31:0]           r_fetch_cnt;
   logic [31:0]           r_write_cnt;
   logic [31:0]           r_mem [c_depth];

   logic [DEPTH_LOG2-1:0] w_idx;
   logic                  w_busy;
   logic                  w_req_changed;

   assign w_idx         = r_addr[DEPTH_LOG2+1:2];
   assign w_busy        = (r_state != S_IDLE);
   assign w_req_changed = (mem_addr != r_addr) || (mem_wdata != r_wdata) ||
                          (mem_wstrb != r_wstrb);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_instr     <= 1'b0;
         r_cnt       <= '0;
         r_ready     <= 1'b0;
         r_err       <= '0;
         r_fetch_cnt <= '0;
         r_write_cnt <= '0;
      end else begin
         // The core must hold its request stable until it sees mem_ready.
         if (w_busy) begin
            if (!mem_valid)
               r_err[0] <= 1'b1;
            if (w_req_changed)
               r_err[1] <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (mem_valid) begin
                  r_addr  <= mem_addr;
                  r_wdata <= mem_wdata;
                  r_wstrb <= mem_wstrb;
                  r_instr <= mem_instr;
                  r_cnt   <= c_wait_init;
                  if (mem_addr[1:0] != 2'b00)
                     r_err[2] <= 1'b1;
                  if (c_has_wait || stall_in) begin
                     r_state <= S_WAIT;
                  end else begin
                     r_state <= S_RESP;
                     r_ready <= 1'b1;
                  end
               end
            end
            S_WAIT: begin
               if (!stall_in) begin
                  if (r_cnt > 8'd1) begin
                     r_cnt <= r_cnt - 8'd1;
                  end else begin
                     r_state <= S_RESP;
                     r_ready <= 1'b1;
                  end
               end
            end
            S_RESP: begin
               r_ready <= 1'b0;
               r_state <= S_IDLE;
               if (r_instr)
                  r_fetch_cnt <= r_fetch_cnt + 32'd1;
               if (r_wstrb != 4'b0000)
                  r_write_cnt <= r_write_cnt + 32'd1;
            end
            default: begin
               r_ready <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Bus write is issued after the backdoor write so its strobed bytes win a collision.
   always_ff @(posedge clk) begin
      if (load_en)
         r_mem[load_addr] <= load_data;
      if (r_state == S_RESP) begin
         for (int b = 0; b < 4; b++) begin
            if (r_wstrb[b])
               r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
         end
      end
   end

   assign mem_ready    = r_ready;
   assign mem_rdata    = r_ready ? r_mem[w_idx] : 32'd0;
   assign protocol_err = r_err;
   assign fetch_count  = r_fetch_cnt;
   assign write_count  = r_write_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_wait_responder.sv
`default_nettype none
// Bench for mem_wait_responder: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_wait_responder;
   localparam int DL    = 8;
   localparam int WC    = 2;
   localparam int DEPTH = 1 << DL;

   logic          clk = 1'b0;
   logic          resetn, mem_valid, mem_instr, mem_ready, stall_in, load_en;
   logic [31:0]   mem_addr, mem_wdata, mem_rdata, load_data, fetch_count, write_count;
   logic [3:0]    mem_wstrb;
   logic [DL-1:0] load_addr;
   logic [2:0]    protocol_err;

   int tests = 0;
   int fails = 0;

   mem_wait_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(WC)) dut (
      .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall_in(stall_in),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .protocol_err(protocol_err), .fetch_count(fetch_count), .write_count(write_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: a pending request completes exactly
   // 1 + WC + (stalled wait cycles) cycles after acceptance.
   logic [31:0] m_mem [DEPTH];
   bit          m_busy = 1'b0;
   int          m_acc, m_stalls;
   int          cyc = 0;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_instr;
   logic [2:0]  m_err = '0;
   logic [31:0] m_fc = '0, m_wc = '0;

   always @(negedge clk) begin
      logic        exp_ready;
      logic [31:0] exp_rdata;
      logic [DL-1:0] idx;
      if (!resetn) begin
         chk("ready", {31'd0, mem_ready}, 32'd0);
         chk("rdata", mem_rdata, 32'd0);
         chk("perr", {29'd0, protocol_err}, 32'd0);
         chk("fetch_cnt", fetch_count, 32'd0);
         chk("write_cnt", write_count, 32'd0);
         m_busy = 1'b0; m_err = '0; m_fc = '0; m_wc = '0;
         if (load_en) m_mem[load_addr] = load_data;
      end else begin
         idx       = m_addr[DL+1:2];
         exp_ready = m_busy && (cyc == m_acc + 1 + WC + m_stalls);
         exp_rdata = exp_ready ? m_mem[idx] : 32'd0;
         chk("ready", {31'd0, mem_ready}, {31'd0, exp_ready});
         chk("rdata", mem_rdata, exp_rdata);
         chk("perr", {29'd0, protocol_err}, {29'd0, m_err});
         chk("fetch_cnt", fetch_count, m_fc);
         chk("write_cnt", write_count, m_wc);
         if (load_en) m_mem[load_addr] = load_data;
         if (m_busy) begin
            if (!mem_valid) m_err[0] = 1'b1;
            if (mem_addr != m_addr || mem_wdata != m_wdata || mem_wstrb != m_wstrb)
               m_err[1] = 1'b1;
            if (exp_ready) begin
               for (int b = 0; b < 4; b++)
                  if (m_wstrb[b]) m_mem[idx][8*b +: 8] = m_wdata[8*b +: 8];
               if (m_instr) m_fc = m_fc + 1;
               if (m_wstrb != 0) m_wc = m_wc + 1;
               m_busy = 1'b0;
            end else if (stall_in) begin
               m_stalls++;
            end
         end else if (mem_valid) begin
            m_addr = mem_addr; m_wdata = mem_wdata; m_wstrb = mem_wstrb; m_instr = mem_instr;
            m_acc = cyc; m_stalls = 0; m_busy = 1'b1;
            if (mem_addr[1:0] != 2'b00) m_err[2] = 1'b1;
         end
      end
      cyc++;
   end

   // One request: k=0 is the accept cycle; returns the offset at which mem_ready was seen.
   task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                      input logic ins, input int smask, input int drop_at, input int chg_at,
                      input int ld_at, input logic [DL-1:0] ld_a, input logic [31:0] ld_d,
                      input bit rnd_ld, output int lat, output logic [31:0] rd);
      lat = -1;
      rd  = '0;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk); #1;
         mem_valid = (k != drop_at);
         mem_instr = ins;
         mem_addr  = (k == chg_at) ? (a ^ 32'h10) : a;
         mem_wdata = wd;
         mem_wstrb = st;
         stall_in  = (k > 0) && (((smask >> k) & 1) != 0);
         load_en   = 1'b0;
         if (k == ld_at) begin
            load_en = 1'b1; load_addr = ld_a; load_data = ld_d;
         end else if (rnd_ld && $urandom_range(3) == 0) begin
            load_en   = 1'b1;
            load_addr = ($urandom_range(1) == 1) ? a[DL+1:2] : DL'($urandom);
            load_data = $urandom;
         end
         @(negedge clk);
         if (mem_ready) begin
            lat = k;
            rd  = mem_rdata;
            break;
         end
      end
      if (lat < 0) begin
         tests++; fails++;
         $display("FAIL txn_timeout: addr 0x%h got no mem_ready, expected one within 60 cycles", a);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         mem_valid = 1'b0; mem_wstrb = '0; stall_in = 1'b0; load_en = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic reset_at(input int k_rst, input logic [31:0] a, input logic [31:0] wd);
      @(posedge clk); #1;
      mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = a; mem_wdata = wd;
      mem_wstrb = 4'hF; stall_in = 1'b0; load_en = 1'b0;
      repeat (k_rst) begin @(posedge clk); #1; end
      resetn = 1'b0; mem_valid = 1'b0; mem_wstrb = '0;
      #1;
      chk("rst_ready", {31'd0, mem_ready}, 32'd0);
      chk("rst_rdata", mem_rdata, 32'd0);
      chk("rst_fetch", fetch_count, 32'd0);
      chk("rst_write", write_count, 32'd0);
      chk("rst_perr", {29'd0, protocol_err}, 32'd0);
      @(posedge clk); #1;
      resetn = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [31:0] rd, a, wd;
      logic [3:0]  st;
      logic        ins;
      int          sm, dr, cg;

      resetn = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0;
      mem_wstrb = '0; stall_in = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
      repeat (3) @(negedge clk);
      chk("reset_ready", {31'd0, mem_ready}, 32'd0);
      chk("reset_perr", {29'd0, protocol_err}, 32'd0);
      chk("reset_fetch", fetch_count, 32'd0);
      @(posedge clk); #1;
      resetn = 1'b1;

      for (int i = 0; i < DEPTH; i++) begin
         @(posedge clk); #1;
         load_en   = 1'b1;
         load_addr = DL'(i);
         case (i)
            3:       load_data = 32'h1122_3344;
            5:       load_data = 32'h00A0_0093;
            7:       load_data = 32'h7777_7777;
            default: load_data = $urandom;
         endcase
      end
      idle(1);

      // Read latency and fetch counting
      txn(32'h14, 32'h0, 4'h0, 1'b1, 0, -1, -1, -1, '0, '0, 1'b0, lat, rd);
      chk("read_latency", lat, 32'd3);
      chk("read_data", rd, 32'h00A0_0093);
      idle(1);
      chk("fetch_count_1", fetch_count, 32'd1);
      chk("write_count_0", write_count, 32'd0);

      // Byte-strobed write returns the pre-write word
      txn(32'h0C, 32'hAABB_CCDD, 4'b0101, 1'b0, 0, -1, -1, -1, '0, '0, 1'b0, lat, rd);
      chk("write_old_data", rd, 32'h1122_3344);
      idle(1);
      chk("write_count_1", write_count, 32'd1);
      txn(32'h0C, 32'h0, 4'h0, 1'b0, 0, -1, -1, -1, '0, '0, 1'b0, lat, rd);
      chk("strobe_merge", rd, 32'h11BB_33DD);

      // Four stalled wait cycles
      txn(32'h14, 32'h0, 4'h0, 1'b0, 32'h1E, -1, -1, -1, '0, '0, 1'b0, lat, rd);
      chk("stall_latency", lat, 32'd7);
      idle(1);
      chk("ready_width", {31'd0, mem_ready}, 32'd0);

      // Load collides with RESP write; load visible to a RESP on the next cycle
      txn(32'h20, 32'h5555_AAAA, 4'b0011, 1'b0, 0, -1, -1, 3, DL'(8), 32'h1234_5678, 1'b0, lat, rd);
      txn(32'h20, 32'h0, 4'h0, 1'b0, 0, -1, -1, -1, '0, '0, 1'b0, lat, rd);
      chk("collision_merge", rd, 32'h1234_AAAA);
      txn(32'h24, 32'h0, 4'h0, 1'b0, 0, -1, -1, 2, DL'(9), 32'hCAFE_F00D, 1'b0, lat, rd);
      chk("load_forward", rd, 32'hCAFE_F00D);

      // Aliasing modulo RAM size
      txn(32'h400, 32'hDEAD_BEEF, 4'hF, 1'b0, 0, -1, -1, -1, '0, '0, 1'b0, lat, rd);
      txn(32'h000, 32'h0, 4'h0, 1'b0, 0, -1, -1, -1, '0, '0, 1'b0, lat, rd);
      chk("alias_read", rd, 32'hDEAD_BEEF);

      // Protocol errors accumulate and stick
      chk("perr_clean", {29'd0, protocol_err}, 32'd0);
      txn(32'h10, 32'h0, 4'h0, 1'b0, 0, 1, -1, -1, '0, '0, 1'b0, lat, rd);
      chk("drop_still_ready", lat, 32'd3);
      idle(1);
      chk("perr_drop", {29'd0, protocol_err}, 32'd1);
      txn(32'h10, 32'h0, 4'h0, 1'b0, 0, -1, 2, -1, '0, '0, 1'b0, lat, rd);
      idle(1);
      chk("perr_change", {29'd0, protocol_err}, 32'd3);
      txn(32'h102, 32'h0, 4'h0, 1'b0, 0, -1, -1, -1, '0, '0, 1'b0, lat, rd);
      idle(1);
      chk("perr_misalign", {29'd0, protocol_err}, 32'd7);
      txn(32'h30, 32'h0, 4'h0, 1'b0, 0, -1, -1, -1, '0, '0, 1'b0, lat, rd);
      idle(1);
      chk("perr_sticky", {29'd0, protocol_err}, 32'd7);

      // Reset abandons in-flight writes to word 7, in WAIT and in RESP
      reset_at(1, 32'h1C, 32'hFFFF_0000);
      reset_at(3, 32'h1C, 32'h0000_FFFF);
      txn(32'h1C, 32'h0, 4'h0, 1'b0, 0, -1, -1, -1, '0, '0, 1'b0, lat, rd);
      chk("reset_no_write", rd, 32'h7777_7777);

      // Randomized traffic
      for (int n = 0; n < 150; n++) begin
         a = $urandom;
         if ($urandom_range(7) != 0) a[1:0] = 2'b00;
         st  = ($urandom_range(1) == 1) ? 4'($urandom) : 4'h0;
         wd  = $urandom;
         ins = (st == 0) && ($urandom_range(1) == 1);
         sm  = ($urandom_range(2) == 0) ? int'($urandom & 32'h7E) : 0;
         dr  = ($urandom_range(9) == 0) ? int'($urandom_range(2, 1)) : -1;
         cg  = ($urandom_range(9) == 0) ? int'($urandom_range(2, 1)) : -1;
         txn(a, wd, st, ins, sm, dr, cg, -1, '0, '0, 1'b1, lat, rd);
         idle(int'($urandom_range(2)));
         if ($urandom_range(39) == 0) begin
            @(posedge clk); #1;
            resetn = 1'b0; mem_valid = 1'b0; load_en = 1'b0;
            @(posedge clk); #1;
            resetn = 1'b1;
         end
      end
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
